// File: rtl/axi_issue_arb_pkg.sv
// Shared types for the AXI issue arbiter: FSM state encoding and its width.
package axi_issue_arb_pkg;

    localparam int STATE_W = 1;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/axi_rr_pick.sv
// Combinational masked round-robin pick: the lowest requester at or above the
// pointer wins; if there is none, the lowest requester overall wins (wrap).
module axi_rr_pick #(
    parameter int PORTS = 4,
    localparam int IDX_W = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDX_W-1:0] pointer,
    output logic [IDX_W-1:0] index,
    output logic             found
);

    logic             hi_found;
    logic [IDX_W-1:0] hi_idx;

    always_comb begin
        index    = '0;
        found    = 1'b0;
        hi_found = 1'b0;
        hi_idx   = '0;
        // Scan downwards so the last hit is the lowest-numbered port.
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                index = IDX_W'(i);
                if (i >= int'(pointer)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
        if (hi_found) begin
            index = hi_idx;
        end
    end

endmodule

// File: rtl/axi_issue_arbiter.sv
// Round-robin address-channel arbiter with an outstanding-transaction limit.
// Define AXI_ISSUE_ARB_QOS_EN to make the highest req_qos win before round-robin.
module axi_issue_arbiter
    import axi_issue_arb_pkg::*;
#(
    parameter int PORTS     = 4,
    parameter int ISSUE     = 4,
    parameter int QOS_WIDTH = 4,
    localparam int IDX_W    = $clog2(PORTS),
    localparam int OUT_W    = $clog2(ISSUE + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PORTS-1:0]           req_valid,
    input  logic [PORTS*QOS_WIDTH-1:0] req_qos,
    output logic [PORTS-1:0]           req_ready,
    output logic                       grant_valid,
    output logic [IDX_W-1:0]           grant_index,
    input  logic                       grant_ready,
    input  logic                       complete,
    output logic [OUT_W-1:0]           outstanding,
    output logic                       err_underflow,
    output arb_state_e                 state_dbg
);

    arb_state_e       state, next_state;
    logic [IDX_W-1:0] pointer;
    logic [PORTS-1:0] cand;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             handshake;
    logic             can_issue;

`ifdef AXI_ISSUE_ARB_QOS_EN
    logic [QOS_WIDTH-1:0] max_qos;

    // Keep only the valid ports carrying the highest priority; RR breaks ties.
    always_comb begin
        max_qos = '0;
        cand    = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (req_valid[i] && req_qos[i*QOS_WIDTH +: QOS_WIDTH] > max_qos) begin
                max_qos = req_qos[i*QOS_WIDTH +: QOS_WIDTH];
            end
        end
        for (int i = 0; i < PORTS; i++) begin
            cand[i] = req_valid[i] && (req_qos[i*QOS_WIDTH +: QOS_WIDTH] == max_qos);
        end
    end
`else
    logic unused_qos;

    assign cand       = req_valid;
    assign unused_qos = ^req_qos;
`endif

    axi_rr_pick #(.PORTS(PORTS)) u_pick (
        .req     (cand),
        .pointer (pointer),
        .index   (pick_idx),
        .found   (pick_found)
    );

    // valid/ready: the grant is offered while in GRANT and cannot be withdrawn;
    // it completes on the first cycle grant_ready is high, which also pulses
    // req_ready for the granted port only.
    assign grant_valid = (state == GRANT);
    assign handshake   = grant_valid & grant_ready;
    assign can_issue   = pick_found && (outstanding < OUT_W'(ISSUE));
    assign state_dbg   = state;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < PORTS; i++) begin
            req_ready[i] = handshake && (grant_index == IDX_W'(i));
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (can_issue)   next_state = GRANT;
            GRANT:   if (grant_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant_index   <= '0;
            pointer       <= '0;
            outstanding   <= '0;
            err_underflow <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && can_issue) begin
                grant_index <= pick_idx;
            end
            if (handshake) begin
                pointer <= (grant_index == IDX_W'(PORTS - 1)) ? '0 : grant_index + IDX_W'(1);
            end
            // A handshake and a completion in the same cycle cancel out.
            unique case ({handshake, complete})
                2'b10: outstanding <= outstanding + OUT_W'(1);
                2'b01: begin
                    if (outstanding == '0) begin
                        err_underflow <= 1'b1;
                    end else begin
                        outstanding <= outstanding - OUT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
